// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: 3x3 window builder at the consumer end of the conv line-delay chain.
// Accepts row-aligned taps (row, row-1, row-2) for one pixel per accept. Shifts them into a
// 3x3 register window and tracks the raster position. It raises a one-cycle oValid pulse
// only for windows lying fully inside the image (valid-mode convolution).
// Optional build macro: CONV_WINDOW_STRIDE2_EN restricts valid windows to stride 2.
module conv_window_ctrl #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 28,
  parameter int unsigned H = 28
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iValid,
  input  logic                iStart,
  input  logic signed [N-1:0] iTap0,
  input  logic signed [N-1:0] iTap1,
  input  logic signed [N-1:0] iTap2,
  output logic [9*N-1:0]      oWin,
  output logic                oValid,
  output logic [7:0]          oRow,
  output logic [7:0]          oCol,
  output logic                oFrameDone
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [7:0] LastCol = 8'(W - 1);
  localparam logic [7:0] LastRow = 8'(H - 1);

  state_e         state_q, state_d;
  logic [7:0]     row_q, row_d;
  logic [7:0]     col_q, col_d;
  logic [9*N-1:0] win_q, win_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;
  logic [7:0]     orow_q, orow_d;
  logic [7:0]     ocol_q, ocol_d;

  logic       accept;
  logic [7:0] pix_row, pix_col;
  logic       last_pix;
  logic       win_ok;

  // Accept decode, position of the accepted pixel, and all next-state values.
  always_comb begin
    accept   = iValid && (iStart || (state_q == StRun));
    // iStart always pins the accepted pixel to (0,0), even mid-frame.
    pix_row  = iStart ? 8'd0 : row_q;
    pix_col  = iStart ? 8'd0 : col_q;
    last_pix = (pix_row == LastRow) && (pix_col == LastCol);
`ifdef CONV_WINDOW_STRIDE2_EN
    // (row-2) even is the same as row even.
    win_ok   = (pix_row >= 8'd2) && (pix_col >= 8'd2) && !pix_row[0] && !pix_col[0];
`else
    win_ok   = (pix_row >= 8'd2) && (pix_col >= 8'd2);
`endif

    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    win_d   = win_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    orow_d  = orow_q;
    ocol_d  = ocol_q;

    if (accept) begin
      // Shift left: column 0 is the oldest pixel, column 2 the newest; row 0 is the top tap.
      for (int r = 0; r < 3; r++) begin
        win_d[(3*r+0)*N +: N] = win_q[(3*r+1)*N +: N];
        win_d[(3*r+1)*N +: N] = win_q[(3*r+2)*N +: N];
      end
      win_d[2*N +: N] = iTap2;
      win_d[5*N +: N] = iTap1;
      win_d[8*N +: N] = iTap0;

      if (last_pix) begin
        row_d   = 8'd0;
        col_d   = 8'd0;
        state_d = StIdle;
      end else begin
        state_d = StRun;
        if (pix_col == LastCol) begin
          col_d = 8'd0;
          row_d = pix_row + 8'd1;
        end else begin
          col_d = pix_col + 8'd1;
          row_d = pix_row;
        end
      end

      valid_d = win_ok;
      done_d  = last_pix;
      if (win_ok) begin
        orow_d = pix_row - 8'd1;
        ocol_d = pix_col - 8'd1;
      end
    end
  end

  // State, position counters, window registers and registered outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= StIdle;
      row_q   <= 8'd0;
      col_q   <= 8'd0;
      win_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      orow_q  <= 8'd0;
      ocol_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
    end
  end

  assign oWin       = win_q;
  assign oValid     = valid_q;
  assign oRow       = orow_q;
  assign oCol       = ocol_q;
  assign oFrameDone = done_q;

endmodule
